// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access encodings, FSM states, request record.
// Purely declarative; no timing of its own.
// No handshake; consumers apply their own flow control.
package dmem_pkg;

    localparam logic [2:0] BHW_B  = 3'b000;
    localparam logic [2:0] BHW_H  = 3'b001;
    localparam logic [2:0] BHW_W  = 3'b010;
    localparam logic [2:0] BHW_BU = 3'b100;
    localparam logic [2:0] BHW_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  bhw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Rejects illegal encodings, misaligned halves/words and addresses past the array.
    function automatic logic access_err(input logic [2:0]  bhw,
                                        input logic [31:0] addr,
                                        input logic [31:0] depth_words);
        logic illegal;
        illegal = !(bhw inside {BHW_B, BHW_H, BHW_W, BHW_BU, BHW_HU});
        return illegal
            || ((bhw == BHW_H || bhw == BHW_HU) && addr[0])
            || ((bhw == BHW_W) && (addr[1:0] != 2'b00))
            || ({2'b00, addr[31:2]} >= depth_words);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the memory unit and the responder.
// Wires only; timing is set by the endpoints.
// Request side is valid/ready; response is an unthrottled single-cycle pulse.
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_bhw;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_bhw, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_bhw, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: write mask, replicated write data and extended read data.
// Purely combinational, zero cycles.
// No handshake; caller qualifies outputs.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  bhw,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic        sext;

    always_comb begin
        rbyte      = rword[{lane, 3'b000} +: 8];
        rhalf      = lane[1] ? rword[31:16] : rword[15:0];
        sext       = !bhw[2];
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rword;
        // Data is replicated across lanes; the mask picks which copy lands.
        case (bhw[1:0])
            BHW_B[1:0]: begin
                be         = 4'b0001 << lane;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{sext & rbyte[7]}}, rbyte};
            end
            BHW_H[1:0]: begin
                be         = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{sext & rhalf[15]}}, rhalf};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store against an internal word array.
// Response pulse LATENCY cycles after acceptance; next accept one cycle after the pulse.
// req_ready low while busy; response has no backpressure.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t        state;
    logic [3:0]    cnt;
    req_t          req_q;
    req_t          cur;
    logic          req_ready_q;
    logic          resp_valid_q;
    logic          resp_err_q;
    logic [31:0]   resp_rdata_q;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [31:0]   rword;
    logic [3:0]    be;
    logic [31:0]   wdata_lane;
    logic [31:0]   rdata_ext;
    logic          err;
    logic          enter_resp;

    // With LATENCY=1 the response is formed straight from the incoming request.
    always_comb begin
        cur = req_q;
        if (state == IDLE) begin
            cur = {bus.req_we, bus.req_bhw, bus.req_addr, bus.req_wdata};
        end
    end

    assign idx        = cur.addr[AW+1:2];
    assign rword      = mem[idx];
    assign err        = access_err(cur.bhw, cur.addr, 32'(DEPTH_WORDS));
    assign enter_resp = ((state == IDLE) && bus.req_valid && (LATENCY == 1))
                     || ((state == WAIT) && (cnt <= 4'd1));

    dmem_lane_align u_lane_align (
        .bhw        (cur.bhw),
        .lane       (cur.addr[1:0]),
        .wdata      (cur.wdata),
        .rword      (rword),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            req_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            if (enter_resp) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= err;
                resp_rdata_q <= (err || cur.we) ? 32'd0 : rdata_ext;
            end
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_q       <= cur;
                        cnt         <= CNT_LOAD;
                        req_ready_q <= 1'b0;
                        state       <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Commit on the edge that closes RESP, so a reset during the pulse drops the store.
    always_ff @(posedge clk) begin
        if ((state == RESP) && req_q.we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed load/store vectors, byte-addressed reference memory,
// and a per-cycle comparison of handshake and response against that reference.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [2:0]  bhw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          due;
    } pend_t;

    pend_t      pend[$];
    logic [7:0] mem_b [DEPTH*4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: memory as a flat byte array, access size taken from the encoding.
    task automatic model(input pend_t p, output logic err, output logic [31:0] rd);
        int          nb;
        bit          legal;
        int          base;
        logic [31:0] v;
        legal = p.bhw inside {BHW_B, BHW_H, BHW_W, BHW_BU, BHW_HU};
        nb    = (p.bhw == BHW_W) ? 4 : ((p.bhw == BHW_H || p.bhw == BHW_HU) ? 2 : 1);
        err   = !legal || ((p.addr % nb) != 0) || ((p.addr >> 2) >= DEPTH);
        rd    = 32'd0;
        if (!err) begin
            base = int'(p.addr);
            if (p.we) begin
                for (int i = 0; i < nb; i++) mem_b[base+i] = p.wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = mem_b[base+i];
                if ((p.bhw == BHW_B || p.bhw == BHW_H) && v[8*nb-1]) begin
                    for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
                end
                rd = v;
            end
        end
    endtask

    always @(negedge clk) begin
        logic        e_err;
        logic [31:0] e_rd;
        bit          due_now;
        if (!rst_n) begin
            pend.delete();
            chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
            chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        end else begin
            due_now = (pend.size() != 0) && (pend[0].due == cyc);
            chk("req_ready", 32'(bus.req_ready), 32'(pend.size() == 0));
            chk("resp_valid", 32'(bus.resp_valid), 32'(due_now));
            if (due_now) begin
                model(pend[0], e_err, e_rd);
                chk("resp_err", 32'(bus.resp_err), 32'(e_err));
                chk("resp_rdata", bus.resp_rdata, e_rd);
                void'(pend.pop_front());
            end
            if (bus.req_valid && bus.req_ready) begin
                pend.push_back('{we: bus.req_we, bhw: bus.req_bhw, addr: bus.req_addr,
                                 wdata: bus.req_wdata, due: cyc + LAT});
            end
        end
    end

    task automatic drive(input logic we, input logic [2:0] bhw,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_we    = we;
        bus.req_bhw   = bhw;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
    endtask

    task automatic wait_accept(output int acc);
        acc = -1;
        for (int i = 0; i < 20 && acc < 0; i++) begin
            @(negedge clk);
            if (bus.req_ready) acc = cyc;
        end
    endtask

    task automatic wait_resp(output int rc, output logic [31:0] rd, output logic er);
        rc = -1;
        rd = 32'd0;
        er = 1'b0;
        for (int i = 0; i < 40 && rc < 0; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                rc = cyc;
                rd = bus.resp_rdata;
                er = bus.resp_err;
            end
        end
    endtask

    task automatic op(input string name, input logic we, input logic [2:0] bhw,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err);
        int          acc;
        int          rc;
        logic [31:0] rd;
        logic        er;
        @(posedge clk); #1;
        drive(we, bhw, addr, wdata);
        wait_accept(acc);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_resp(rc, rd, er);
        if (acc < 0 || rc < 0) begin
            chk({name, "_timeout"}, 32'(acc >= 0 && rc >= 0), 32'd1);
        end else begin
            chk({name, "_rdata"}, rd, exp_rd);
            chk({name, "_err"}, 32'(er), 32'(exp_err));
            chk({name, "_lat"}, 32'(rc - acc), 32'(LAT));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d assertions evaluated", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int          a1;
        int          a2;
        int          r2;
        int          pulses;
        logic [31:0] rd2;
        logic        er2;

        for (int i = 0; i < DEPTH*4; i++) mem_b[i] = 8'h00;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_bhw   = BHW_W;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("reset_resp_rdata", bus.resp_rdata, 32'd0);
        chk("reset_resp_err", 32'(bus.resp_err), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        op("sw100",   1'b1, BHW_W,  32'h100, 32'hDEADBEEF, 32'h0,        1'b0);
        op("lw100a",  1'b0, BHW_W,  32'h100, 32'h0,        32'hDEADBEEF, 1'b0);
        op("sb101",   1'b1, BHW_B,  32'h101, 32'h000000A5, 32'h0,        1'b0);
        op("lw100b",  1'b0, BHW_W,  32'h100, 32'h0,        32'hDEADA5EF, 1'b0);
        op("lb101",   1'b0, BHW_B,  32'h101, 32'h0,        32'hFFFFFFA5, 1'b0);
        op("lbu101",  1'b0, BHW_BU, 32'h101, 32'h0,        32'h000000A5, 1'b0);
        op("sh102",   1'b1, BHW_H,  32'h102, 32'h00008001, 32'h0,        1'b0);
        op("lh102",   1'b0, BHW_H,  32'h102, 32'h0,        32'hFFFF8001, 1'b0);
        op("lhu102",  1'b0, BHW_HU, 32'h102, 32'h0,        32'h00008001, 1'b0);
        op("lw100c",  1'b0, BHW_W,  32'h100, 32'h0,        32'h8001A5EF, 1'b0);

        op("lw102_mis", 1'b0, BHW_W,  32'h102,  32'h0,      32'h0, 1'b1);
        op("sh103_mis", 1'b1, BHW_H,  32'h103,  32'h0000FFFF, 32'h0, 1'b1);
        op("bhw011",    1'b0, 3'b011, 32'h100,  32'h0,      32'h0, 1'b1);
        op("lw1000_oor",1'b0, BHW_W,  32'h1000, 32'h0,      32'h0, 1'b1);
        op("lw100d",    1'b0, BHW_W,  32'h100,  32'h0,      32'h8001A5EF, 1'b0);

        op("sw_last", 1'b1, BHW_W, 32'hFFC, 32'hCAFEF00D, 32'h0,        1'b0);
        op("lw_last", 1'b0, BHW_W, 32'hFFC, 32'h0,        32'hCAFEF00D, 1'b0);
        op("lb_neg",  1'b0, BHW_B, 32'hFFD, 32'h0,        32'hFFFFFFF0, 1'b0);

        // Back-to-back: valid held high across the busy window.
        @(posedge clk); #1;
        drive(1'b1, BHW_W, 32'h204, 32'h33333333);
        wait_accept(a1);
        @(posedge clk); #1;
        drive(1'b0, BHW_W, 32'h204, 32'h0);
        wait_accept(a2);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_resp(r2, rd2, er2);
        chk("b2b_accept_gap", 32'(a2 - a1), 32'd3);
        chk("b2b_resp_gap", 32'(r2 - a1), 32'd5);
        chk("b2b_rdata", rd2, 32'h33333333);
        chk("b2b_err", 32'(er2), 32'd0);

        // Store interrupted by reset must not land.
        op("sw200a", 1'b1, BHW_W, 32'h200, 32'h11111111, 32'h0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, BHW_W, 32'h200, 32'h22222222);
        wait_accept(a1);
        chk("rst_store_accepted", 32'(a1 >= 0), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst_n         = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.resp_valid) pulses++;
        end
        chk("rst_no_resp", 32'(pulses), 32'd0);
        op("lw200", 1'b0, BHW_W, 32'h200, 32'h0, 32'h11111111, 1'b0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the slave end of the load/store request issued by the pipeline's memory functional unit.
- Accepts one request at a time through a valid/ready handshake, holds it for a configurable access latency, then returns a single-cycle response pulse.
- Supports RISC-V byte/half/word access encodings: lane-aligned partial writes, sign/zero-extended reads, and error flagging for misaligned, illegal or out-of-range accesses.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the internal array (power of two).
- LATENCY, 2, cycles from request acceptance to resp_valid (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_bhw  in  3  access encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/110/111 are illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_err  out  1  request rejected; valid only with resp_valid.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1.
  - Latency counter cleared.
  - Array contents are not reset; simulation initialises them to 0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - req_valid=1 accepts the request (cycle T): we, bhw, addr and wdata are latched, and the counter loads LATENCY-1.
  - If LATENCY=1, next state is RESP; otherwise next state is WAIT.
- WAIT:
  - req_ready=0.
  - The counter decrements each cycle; at 0 the next state is RESP.
  - Input changes are ignored.
- RESP:
  - resp_valid=1 for exactly cycle T+LATENCY, with resp_rdata and resp_err registered.
  - A non-error store commits to the array on this clock edge.
  - req_ready=0; next state is IDLE.
  - Earliest next acceptance is T+LATENCY+1, so peak throughput is one request per LATENCY+1 cycles.
- There is no response backpressure; the requester must sample the pulse.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; lane = addr[1:0].
- resp_err=1 when any of the following holds:
  - req_bhw is illegal;
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0;
  - addr[31:2] >= DEPTH_WORDS.
- On error: no write, resp_rdata=0.
- Stores:
  - B writes lane addr[1:0] with wdata[7:0].
  - H writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - W writes all four lanes.
  - Other lanes are unchanged.
  - BU/HU on a store behave as B/H.
- Loads:
  - The selected byte or half is extracted from the latched word index.
  - B/H sign-extend; BU/HU zero-extend; W passes the word through.
  - Data is read in RESP, so a load issued after a store's response sees the stored value.
- Reset mid-operation (WAIT or RESP before its edge): the pending request is discarded, a pending store is not committed, and no resp_valid is produced.

Decomposition:
- Shared package dmem_pkg holds:
  - BHW encoding constants (BHW_B, BHW_H, BHW_W, BHW_BU, BHW_HU);
  - the state enum (IDLE, WAIT, RESP);
  - the error-check function.
- One combinational sub-module, dmem_lane_align. It takes bhw, addr[1:0], wdata and the stored word, and produces the 4-bit byte-write mask, the lane-shifted write data and the extended read data.
- The FSM, counter and array stay in dmem_responder.

Test Plan:
- Reset, SW 0x100 = 0xDEADBEEF accepted at T → resp_valid only at T+2, err=0; then LW 0x100 → rdata 0xDEADBEEF.
- SB 0x101 = 0x000000A5, then:
  - LW 0x100 → 0xDEADA5EF;
  - LB 0x101 → 0xFFFFFFA5;
  - LBU 0x101 → 0x000000A5.
- SH 0x102 = 0x00008001, then:
  - LH 0x102 → 0xFFFF8001;
  - LHU 0x102 → 0x00008001;
  - LW 0x100 → 0x8001A5EF.
- Error cases, each returning resp_err=1 and rdata=0 with memory unchanged:
  - LW 0x102;
  - SH 0x103;
  - bhw=011;
  - LW 0x1000 (DEPTH 1024).
- req_valid held high from T → req_ready low at T+1..T+2, second request accepted exactly at T+3, its response at T+5.
- SW 0x200 = 0x11111111 completes. Then SW 0x200 = 0x22222222 with rst_n pulsed low at T+1 → no resp_valid; subsequent LW 0x200 → 0x11111111.
